mul_sequencer: RTL

- Multi-cycle shift-add multiplier FSM that computes the low WIDTH bits of a signed product.
- It has no adder of its own: every partial-product add is requested from the shared ALU through cpu_arbiter's MUL request port.
- It sits beside cpu_arbiter. The arbiter raises start when a MUL C-instruction is decoded, and holds the CPU stalled until done.

---
 rtl/mul_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// ----------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle shift-add multiplier. It returns the low WIDTH bits of x_in*y_in.
//   The two's-complement low product equals the unsigned low product, so the
//   block does no sign handling. The block has no adder of its own. Every
//   partial-product add goes to the shared ALU through the arbiter's MUL port.
//
// Optional feature (macro MUL_EARLY_EXIT_EN):
//   When the macro is defined, iteration also stops once the remaining
//   multiplier bits are all zero. The result does not change.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        one-cycle pulse; x_in/y_in are sampled when it is accepted (IDLE only)
//   x_in, y_in   multiplicand / multiplier
//   req_alu      shared-ALU request; alu_op/alu_x/alu_y are 0 when it is low
//   alu_result   combinational ALU sum, returned in the same cycle as req_alu
//   busy         high while iterating
//   done         one-cycle pulse when the product is complete
//   result       product; held until the next operation completes
// ----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter logic [5:0]  ADD_OP = 6'b000010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             req_alu,
    output logic [5:0]       alu_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CntW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_result;
    logic              w_add;
    logic              w_early;

    // An add is needed only when the current multiplier bit is set.
    assign w_add = (r_state == StIter) && r_mplier[0];

`ifdef MUL_EARLY_EXIT_EN
    assign w_early = ((r_mplier >> 1) == '0);
`else
    assign w_early = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_next = StIter;
            StIter: if ((r_cnt == CntLast) || w_early) w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= x_in;
                        r_mplier <= y_in;
                        r_cnt    <= '0;
                    end
                end
                StIter: begin
                    if (w_add) r_acc <= alu_result;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                StDone: r_result <= r_acc;
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        req_alu = w_add;
        alu_op  = w_add ? ADD_OP : 6'd0;
        alu_x   = w_add ? r_acc : '0;
        alu_y   = w_add ? r_mcand : '0;
        busy    = (r_state == StIter);
        done    = (r_state == StDone);
        // Bypass the finished accumulator so the result is already valid during done.
        result  = (r_state == StDone) ? r_acc : r_result;
    end

endmodule
